// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, edge or center
// aligned, with double-buffered duties that commit at the period boundary.
module pwm_multi #(
  parameter int CLK_FREQ = 1_000_000,
  parameter int PWM_FREQ = 1000,
  parameter int CHANNELS = 4,
  parameter int RES      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*RES-1:0]  duty_in,
  input  logic                     load,
  input  logic                     center,
  input  logic [CHANNELS-1:0]      en,
  output logic [CHANNELS-1:0]      pwm_out,
  output logic                     period_start,
  output logic                     load_pending
);

  localparam int DIV_RAW = CLK_FREQ / (PWM_FREQ * (2 ** RES));
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]  PLAST = PW'(DIV - 1);
  localparam logic [PW-1:0]  PONE  = PW'(1);
  localparam logic [RES-1:0] MAX   = '1;
  localparam logic [RES-1:0] ONE   = RES'(1);
  localparam logic [RES-1:0] MAXM1 = MAX - ONE;

  logic [PW-1:0]  presc;
  logic [RES-1:0] cnt;
  logic           dir;
  logic           mode;
  logic           tick;
  logic           bnd;
  logic [RES-1:0] active [CHANNELS];
  logic [RES-1:0] shadow [CHANNELS];

  assign tick = (presc == PLAST);

  // dir is only ever set in center mode, so edge mode just wraps at MAX.
  assign bnd = tick && (mode ? (dir && cnt == ONE) : (cnt == MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc        <= '0;
      cnt          <= '0;
      dir          <= 1'b0;
      mode         <= 1'b0;
      load_pending <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      presc <= tick ? '0 : presc + PONE;

      if (bnd) begin
        cnt  <= '0;
        dir  <= 1'b0;
        mode <= center;
      end else if (tick) begin
        if (dir) begin
          cnt <= cnt - ONE;
        end else begin
          cnt <= cnt + ONE;
          if (mode && cnt == MAXM1)
            dir <= 1'b1;
        end
      end

      // Commit uses the old shadow even when a load lands on the boundary.
      if (bnd && load_pending)
        for (int i = 0; i < CHANNELS; i++)
          active[i] <= shadow[i];

      if (load) begin
        for (int i = 0; i < CHANNELS; i++)
          shadow[i] <= duty_in[i*RES +: RES];
        load_pending <= 1'b1;
      end else if (bnd) begin
        load_pending <= 1'b0;
      end

      period_start <= bnd;

      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= en[i] && (cnt < active[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-time model checked every cycle, plus
// hand-computed high times, periods and edge-case pins.
module tb_pwm_multi;

  localparam int CH  = 4;
  localparam int RES = 4;
  localparam int MAX = 15;
  localparam int DIV = 62;
  localparam int PE  = 992;
  localparam int PC  = 1860;

  logic            clk;
  logic            rst;
  logic [CH*RES-1:0] duty_in;
  logic            load;
  logic            center;
  logic [CH-1:0]   en;
  logic [CH-1:0]   pwm_out;
  logic            period_start;
  logic            load_pending;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_multi #(
    .CLK_FREQ(1_000_000),
    .PWM_FREQ(1000),
    .CHANNELS(CH),
    .RES(RES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .duty_in(duty_in),
    .load(load),
    .center(center),
    .en(en),
    .pwm_out(pwm_out),
    .period_start(period_start),
    .load_pending(load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position in the period t (clocks) determines the counter value.
  int       t;
  bit       mmode;
  bit       mpend;
  int       mact [CH];
  int       msh  [CH];
  bit [CH-1:0] exp_pwm;
  bit       exp_ps;
  bit       exp_lp;
  bit       mvalid = 0;

  always @(posedge clk) begin
    int k;
    int c;
    int per;
    bit b;
    if (!rst) begin
      t = 0;
      mmode = 0;
      mpend = 0;
      for (int i = 0; i < CH; i++) begin
        mact[i] = 0;
        msh[i] = 0;
      end
      exp_pwm = '0;
      exp_ps = 0;
      exp_lp = 0;
      mvalid = 1;
    end else begin
      k = t / DIV;
      c = (mmode && k > MAX) ? 2 * MAX - k : k;
      for (int i = 0; i < CH; i++)
        exp_pwm[i] = en[i] && (c < mact[i]);
      per = (mmode ? 2 * MAX : MAX + 1) * DIV;
      b = (t == per - 1);
      exp_ps = b;
      if (b) begin
        t = 0;
        mmode = center;
        if (mpend)
          for (int i = 0; i < CH; i++)
            mact[i] = msh[i];
      end else begin
        t++;
      end
      if (load) begin
        for (int i = 0; i < CH; i++)
          msh[i] = int'(duty_in[i*RES +: RES]);
        mpend = 1;
      end else if (b) begin
        mpend = 0;
      end
      exp_lp = mpend;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      n_cmp++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps ||
          load_pending !== exp_lp) begin
        n_bad++;
        $display("FAIL model @%0t: pwm=%b/%b ps=%b/%b lp=%b/%b (got/exp)",
                 $time, pwm_out, exp_pwm, period_start, exp_ps,
                 load_pending, exp_lp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int waited;

  task automatic wait_ps(input string name);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!period_start && waited < 4000);
    if (!period_start)
      check({name, "_timeout"}, 0, 1);
  endtask

  int hi  [CH];
  int fst [CH];
  int lst [CH];
  int ps_at;
  int lp_hi;

  task automatic measure(input int p);
    ps_at = 0;
    lp_hi = 0;
    for (int c = 0; c < CH; c++) begin
      hi[c] = 0;
      fst[c] = 0;
      lst[c] = 0;
    end
    for (int j = 1; j <= p; j++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        hi[c] += int'(pwm_out[c]);
        if (j == 1) fst[c] = int'(pwm_out[c]);
        if (j == p) lst[c] = int'(pwm_out[c]);
      end
      if (period_start && ps_at == 0) ps_at = j;
      lp_hi += int'(load_pending);
    end
  endtask

  task automatic set_duty(input int ch, input int v);
    duty_in[ch*RES +: RES] = RES'(v);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b0;
    center = 1'b0;
    en = '1;
    duty_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    wait_ps("first_ps");
    check("first_ps_delay", waited, PE);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_lp", int'(load_pending), 0);
    measure(PE);
    check("edge_period", ps_at, PE);
    check("idle_high", hi[0] + hi[1] + hi[2] + hi[3], 0);

    duty_in = 16'hF840;
    pulse_load();
    check("lp_rise", int'(load_pending), 1);
    wait_ps("edge_load");
    measure(PE);
    check("edge_d0", hi[0], 0);
    check("edge_d4", hi[1], 248);
    check("edge_d8", hi[2], 496);
    check("edge_d15", hi[3], 930);
    check("edge_lp_clear", lp_hi, 0);

    center = 1'b1;
    set_duty(1, 4);
    pulse_load();
    wait_ps("center_switch");
    measure(PC);
    check("center_period", ps_at, PC);
    check("center_d4", hi[1], 434);
    check("center_d8", hi[2], 930);
    check("center_d15", hi[3], 1798);
    check("center_sym_first", fst[1], 1);
    check("center_sym_last", lst[1], 1);

    center = 1'b0;
    set_duty(0, 8);
    pulse_load();
    repeat (5) @(negedge clk);
    set_duty(0, 12);
    pulse_load();
    wait_ps("dbuf");
    measure(PE);
    check("dbuf_d12", hi[0], 744);
    check("dbuf_period", ps_at, PE);

    set_duty(0, 3);
    pulse_load();
    repeat (PE - 2) @(negedge clk);
    set_duty(0, 10);
    pulse_load();
    check("b_align", int'(period_start), 1);
    check("lp_hold", int'(load_pending), 1);
    measure(PE);
    check("coinc_old", hi[0], 186);
    check("coinc_lp", lp_hi, PE - 1);
    measure(PE);
    check("coinc_new", hi[0], 620);
    check("coinc_lp_clr", lp_hi, 0);

    waited = 0;
    while (!pwm_out[2] && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("ch2_high", int'(pwm_out[2]), 1);
    en[2] = 1'b0;
    @(negedge clk);
    check("en_drop", int'(pwm_out[2]), 0);
    en[2] = 1'b1;

    set_duty(1, 5);
    pulse_load();
    repeat (100) @(negedge clk);
    check("lp_before_rst", int'(load_pending), 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_lp", int'(load_pending), 0);
    check("rst_ps", int'(period_start), 0);
    rst = 1'b1;

    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      load = ($urandom_range(0, 49) == 0);
      duty_in = 16'($urandom);
      if ($urandom_range(0, 199) == 0) en = 4'($urandom);
      if ($urandom_range(0, 2999) == 0) center = ~center;
      rst = ($urandom_range(0, 4999) != 0);
    end
    rst = 1'b1;
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator; parametrised successor to the single-channel `pwm` block. It drives CHANNELS outputs from one shared prescaler and period counter, with RES-bit duty resolution, runtime-selectable edge-aligned or center-aligned mode, and per-channel enables. Duty values are double-buffered: a software write lands in a shadow register and takes effect only at the next period boundary, so outputs never glitch mid-period. It sits between the control/register logic and the output pins, with `period_start` available for ADC or event synchronisation.

## Interface
- CLK_FREQ, 1_000_000: clock frequency in Hz.
- PWM_FREQ, 1000: nominal edge-mode PWM frequency in Hz.
- CHANNELS, 4: number of PWM outputs, minimum 1.
- RES, 8: duty/counter width in bits, minimum 2.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- duty_in  input  CHANNELS*RES  duty for all channels; channel i uses bits [i*RES +: RES].
- load  input  1  one-cycle strobe that captures duty_in into the shadow registers.
- center  input  1  mode request (0 = edge, 1 = center); sampled only at a period boundary.
- en  input  CHANNELS  per-channel enable; read directly every cycle, not buffered.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_start  output  1  one-cycle pulse per period boundary.
- load_pending  output  1  high while shadow duties await transfer.

## Operation
- MAX = 2^RES-1. DIV = CLK_FREQ/(PWM_FREQ*2^RES), integer division; DIV is forced to 1 if the result is below 1.
- Prescaler:
  - Counts 0..DIV-1.
  - tick is asserted on the cycle where prescaler == DIV-1; the prescaler then wraps to 0.
- Counter `cnt` (RES bits) and direction flag `dir` advance only on tick.
- Edge mode:
  - Sequence is 0,1,…,MAX, then wraps to 0; period = 2^RES ticks.
  - Boundary B = tick && cnt == MAX.
- Center mode:
  - Sequence is 0,1,…,MAX,MAX-1,…,1, then 0; period = 2*MAX ticks.
  - dir turns to down on the tick where cnt reaches MAX.
  - Boundary B = tick && dir == down && cnt == 1.
- On B:
  - cnt <= 0, dir <= up.
  - The active mode register <= `center`.
  - If load_pending is set, active duty <= shadow duty for all channels and load_pending clears.
- Compare, every clk: pwm_out[i] <= en[i] && (cnt < active_duty[i]). The result is registered, so the output lags cnt by 1 clk.
- High time per period:
  - Edge mode: duty ticks. duty = MAX gives MAX/2^RES, so 100% is not reachable; duty = 0 gives constant low.
  - Center mode: 2*duty-1 ticks for duty ≥ 1, 0 ticks for duty = 0. The pulse is symmetric about cnt = 0.
- Shadow registers:
  - A `load` strobe copies duty_in into the shadow registers and sets load_pending.
  - Repeated loads before a boundary overwrite the shadow; the last write wins.
- load on the same cycle as B:
  - Active duty takes the old shadow.
  - The shadow takes the new duty_in and load_pending stays 1.
  - The new value is applied at the following boundary.
- Changing `center` mid-period has no effect until the next B.
- Deasserting en[i] forces pwm_out[i] low one clk later, regardless of phase.

## Timing
- Reset (rst low at a clk edge) clears:
  - prescaler = 0, cnt = 0, dir = up, mode = edge.
  - All active and shadow duties = 0, load_pending = 0.
  - pwm_out = 0, period_start = 0.
- Reset asserted mid-operation aborts the period and discards any pending load.
- The first period starts on the first cycle after rst rises. No period_start pulse is issued for that start.
- period_start is registered: it is high for exactly one clk, on the cycle after B (when cnt == 0 first holds).
- load_pending rises 1 clk after `load`. It falls 1 clk after B, except in the simultaneous load-and-B case above.
- New duty appears on pwm_out 1 clk after period_start rises.
- Throughput: a new load is accepted every cycle; there is no backpressure.

## Test plan
All cases use CLK_FREQ=1_000_000, PWM_FREQ=1000, RES=4, CHANNELS=4. This gives DIV=62, an edge period of 992 clk and a center period of 1860 clk.
- Reset behaviour: hold rst low for 3 clk, release, no load -> pwm_out = 0 for all channels and load_pending = 0; period_start pulses every 992 clk, with the first pulse 992 clk after release.
- Edge-mode duties: load duties {0,4,8,15}, all enabled -> from the next boundary, high times per period are 0, 248, 496 and 930 clk.
- Center mode: set center = 1, load duty 4 on channel 1 -> after the mode takes effect, period is 1860 clk and channel 1 is high for 434 clk per period, symmetric around period_start.
- Double buffering: load 8, then load 12 before the boundary -> channel 0 goes directly from its old duty to 744 clk high; the value 8 never appears on the output.
- Load coincident with boundary: pulse load on exactly the cycle of B -> old shadow applied now, new value applied one period later, load_pending high throughout.
- Enable and mid-period reset: drop en[2] mid-pulse -> pwm_out[2] is low 1 clk later; assert rst mid-period -> all outputs 0 and load_pending cleared on the next edge.
